// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 effects driver: command bytes, effect and
// main-FSM enums, and the fixed message ROM.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_DISP_OFF = 8'h08;
    localparam logic [7:0] CMD_SHL      = 8'h18;
    localparam logic [7:0] CMD_SHR      = 8'h1C;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;
    localparam logic [7:0] CMD_FUNC_1L  = 8'h20;
    localparam logic [7:0] CMD_FUNC_2L  = 8'h28;

    typedef enum logic [2:0] {
        EffStatic      = 3'd0,
        EffScrollLeft  = 3'd1,
        EffScrollRight = 3'd2,
        EffBlink       = 3'd3,
        EffTypewriter  = 3'd4
    } effect_e;

    typedef enum logic [2:0] {
        StPor,
        StInit,
        StClearWait,
        StWrite,
        StFrame,
        StStep
    } state_e;

    // First 16 characters go on line 1, the rest on line 2 (two-line builds).
    localparam logic [255:0] MSG_ROM = "HD44780 EFFECTS!SCROLL BLINK TYP";

    function automatic logic [7:0] msg_char(input logic [4:0] idx);
        return MSG_ROM[{5'd31 - idx, 3'b000} +: 8];
    endfunction

    // Reserved select codes collapse to static so they never count as a change.
    function automatic effect_e ef_decode(input logic [2:0] raw);
        effect_e ef;
        case (raw)
            3'd1:    ef = EffScrollLeft;
            3'd2:    ef = EffScrollRight;
            3'd3:    ef = EffBlink;
            3'd4:    ef = EffTypewriter;
            default: ef = EffStatic;
        endcase
        return ef;
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// 4-bit HD44780 transmitter: accepts a byte (or a single nibble) on a
// valid/ready handshake and produces the setup / E strobe / settle timing.
module lcd_nibble_tx #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    input  logic       data_rs,
    input  logic       nibble_only,
    output logic       ready,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_d
);

    // Per nibble: cycle 0 setup, 1 strobe, 2 hold, 3..LAST settle.
    localparam int unsigned LAST = 2 + SETTLE_CYCLES;
    localparam int unsigned CW   = $clog2(LAST + 1);

    logic          busy_q, busy_d;
    logic          low_pend_q, low_pend_d;
    logic [3:0]    low_q, low_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [3:0]    d_q, d_d;

    // Next-state: load on accept, walk the nibble phases, chain the low nibble.
    always_comb begin
        busy_d     = busy_q;
        low_pend_d = low_pend_q;
        low_d      = low_q;
        cnt_d      = cnt_q;
        rs_d       = rs_q;
        d_d        = d_q;
        e_d        = 1'b0;
        if (!busy_q) begin
            if (valid) begin
                busy_d     = 1'b1;
                cnt_d      = '0;
                d_d        = nibble_only ? data[3:0] : data[7:4];
                low_d      = data[3:0];
                low_pend_d = !nibble_only;
                rs_d       = data_rs;
            end
        end else begin
            e_d = (cnt_q == '0);
            if (cnt_q == CW'(LAST)) begin
                if (low_pend_q) begin
                    d_d        = low_q;
                    low_pend_d = 1'b0;
                    cnt_d      = '0;
                end else begin
                    busy_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers; reset drops E at once even mid-strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            low_pend_q <= 1'b0;
            low_q      <= '0;
            cnt_q      <= '0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            d_q        <= '0;
        end else begin
            busy_q     <= busy_d;
            low_pend_q <= low_pend_d;
            low_q      <= low_d;
            cnt_q      <= cnt_d;
            e_q        <= e_d;
            rs_q       <= rs_d;
            d_q        <= d_d;
        end
    end

    assign ready  = !busy_q;
    assign lcd_e  = e_q;
    assign lcd_rs = rs_q;
    assign lcd_d  = d_q;

endmodule

// File: rtl/lcd_effects_driver.sv
// HD44780 character-LCD driver (4-bit mode): power-on init, message write
// from ROM, then per-frame scroll / blink / typewriter effects chosen by EF.
// Optional feature macro LCD_TWO_LINE_EN: 2-line function set, up to 32
// characters with a line-2 address command before character 16.
module lcd_effects_driver
    import lcd_pkg::*;
#(
    parameter int unsigned MSG_LEN       = 16,
    parameter int unsigned POR_CYCLES    = 32,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CLEAR_CYCLES  = 64,
    parameter int unsigned FRAME_CYCLES  = 256
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] EF,
    output logic       RS,
    output logic       E,
    output logic [3:0] D,
    output logic [1:0] LED
);

`ifdef LCD_TWO_LINE_EN
    localparam bit TWO_LINE = 1'b1;
`else
    localparam bit TWO_LINE = 1'b0;
`endif
    localparam int unsigned MSG_MAX  = TWO_LINE ? 32 : 16;
    localparam int unsigned MSG_EFF  = (MSG_LEN > MSG_MAX) ? MSG_MAX : MSG_LEN;
    localparam logic [7:0]  FUNC_SET = TWO_LINE ? CMD_FUNC_2L : CMD_FUNC_1L;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  chr_q, chr_d;
    logic        line_pend_q, line_pend_d;
    logic        gap_done_q, gap_done_d;
    logic        ret_write_q, ret_write_d;
    logic [2:0]  ef_s1_q, ef_s2_q;
    effect_e     ef_cur_q, ef_cur_d, ef_new;
    logic        changed_q, changed_d;
    logic        blink_q, blink_d;
    logic        led_hb_q, led_hb_d;
    logic        led_busy_q, led_busy_d;

    logic        tx_valid, tx_ready, tx_rs, tx_nib;
    logic [7:0]  tx_data;

    lcd_nibble_tx #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_tx (
        .clk         (CLK),
        .rst_n       (RST),
        .valid       (tx_valid),
        .data        (tx_data),
        .data_rs     (tx_rs),
        .nibble_only (tx_nib),
        .ready       (tx_ready),
        .lcd_e       (E),
        .lcd_rs      (RS),
        .lcd_d       (D)
    );

    // Main sequencer; a transfer is accepted whenever tx_valid meets tx_ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        chr_d       = chr_q;
        line_pend_d = line_pend_q;
        gap_done_d  = gap_done_q;
        ret_write_d = ret_write_q;
        ef_cur_d    = ef_cur_q;
        changed_d   = changed_q;
        blink_d     = blink_q;
        led_hb_d    = led_hb_q;
        ef_new      = ef_decode(ef_s2_q);
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        tx_rs       = 1'b0;
        tx_nib      = 1'b0;

        unique case (state_q)
            StPor: begin
                if (cnt_q == 32'(POR_CYCLES - 1)) begin
                    state_d = StInit;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StInit: begin
                tx_valid = 1'b1;
                tx_nib   = (idx_q < 3'd4);
                case (idx_q)
                    3'd0, 3'd1, 3'd2: tx_data = 8'h03;
                    3'd3:             tx_data = 8'h02;
                    3'd4:             tx_data = FUNC_SET;
                    3'd5:             tx_data = CMD_DISP_ON;
                    3'd6:             tx_data = CMD_ENTRY;
                    default:          tx_data = CMD_CLEAR;
                endcase
                if (tx_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d     = StClearWait;
                        cnt_d       = '0;
                        ret_write_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            // Idle time only starts once the last command has left the wire.
            StClearWait: begin
                if (tx_ready) begin
                    if (cnt_q == 32'(CLEAR_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (ret_write_q) begin
                            state_d     = StWrite;
                            chr_d       = '0;
                            line_pend_d = 1'b1;
                            gap_done_d  = 1'b0;
                        end else begin
                            state_d = StFrame;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end

            StWrite: begin
                if (line_pend_q) begin
                    tx_valid = 1'b1;
                    tx_data  = (chr_q == 6'd0) ? CMD_LINE1 : CMD_LINE2;
                    if (tx_ready) begin
                        line_pend_d = 1'b0;
                    end
                end else if (chr_q == 6'(MSG_EFF)) begin
                    if (tx_ready) begin
                        state_d = StFrame;
                        cnt_d   = '0;
                    end
                end else if (ef_cur_q == EffTypewriter && !gap_done_q) begin
                    if (tx_ready) begin
                        if (cnt_q == 32'(FRAME_CYCLES - 1)) begin
                            gap_done_d = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                end else begin
                    tx_valid = 1'b1;
                    tx_rs    = 1'b1;
                    tx_data  = msg_char(chr_q[4:0]);
                    if (tx_ready) begin
                        chr_d      = chr_q + 6'd1;
                        gap_done_d = 1'b0;
                        if (TWO_LINE && chr_q == 6'd15 && MSG_EFF > 16) begin
                            line_pend_d = 1'b1;
                        end
                    end
                end
            end

            StFrame: begin
                if (cnt_q == 32'(FRAME_CYCLES - 1)) begin
                    state_d   = StStep;
                    cnt_d     = '0;
                    idx_d     = '0;
                    led_hb_d  = !led_hb_q;
                    ef_cur_d  = ef_new;
                    changed_d = (ef_new != ef_cur_q);
                    if (ef_new != ef_cur_q) begin
                        blink_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StStep: begin
                if (changed_q) begin
                    tx_valid = 1'b1;
                    tx_data  = (idx_q == 3'd0) ? CMD_HOME : CMD_DISP_ON;
                    if (tx_ready) begin
                        if (idx_q == 3'd0) begin
                            idx_d = 3'd1;
                        end else begin
                            state_d     = StClearWait;
                            cnt_d       = '0;
                            ret_write_d = 1'b0;
                        end
                    end
                end else if (idx_q != 3'd0) begin
                    // Command handed off; return once it is fully sent.
                    if (tx_ready) begin
                        state_d = StFrame;
                        cnt_d   = '0;
                    end
                end else begin
                    case (ef_cur_q)
                        EffScrollLeft, EffScrollRight: begin
                            tx_valid = 1'b1;
                            tx_data  = (ef_cur_q == EffScrollLeft) ? CMD_SHL : CMD_SHR;
                            if (tx_ready) begin
                                idx_d = 3'd1;
                            end
                        end
                        EffBlink: begin
                            tx_valid = 1'b1;
                            tx_data  = blink_q ? CMD_DISP_ON : CMD_DISP_OFF;
                            if (tx_ready) begin
                                idx_d   = 3'd1;
                                blink_d = !blink_q;
                            end
                        end
                        EffTypewriter: begin
                            tx_valid = 1'b1;
                            tx_data  = CMD_CLEAR;
                            if (tx_ready) begin
                                state_d     = StClearWait;
                                cnt_d       = '0;
                                ret_write_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d = StFrame;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            default: begin
                state_d = StPor;
                cnt_d   = '0;
            end
        endcase

        led_busy_d = (state_d != StFrame) && (state_d != StPor);
    end

    // State, counters, synchroniser and LED registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StPor;
            cnt_q       <= '0;
            idx_q       <= '0;
            chr_q       <= '0;
            line_pend_q <= 1'b0;
            gap_done_q  <= 1'b0;
            ret_write_q <= 1'b0;
            ef_s1_q     <= '0;
            ef_s2_q     <= '0;
            ef_cur_q    <= EffStatic;
            changed_q   <= 1'b0;
            blink_q     <= 1'b0;
            led_hb_q    <= 1'b0;
            led_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            chr_q       <= chr_d;
            line_pend_q <= line_pend_d;
            gap_done_q  <= gap_done_d;
            ret_write_q <= ret_write_d;
            ef_s1_q     <= EF;
            ef_s2_q     <= ef_s1_q;
            ef_cur_q    <= ef_cur_d;
            changed_q   <= changed_d;
            blink_q     <= blink_d;
            led_hb_q    <= led_hb_d;
            led_busy_q  <= led_busy_d;
        end
    end

    assign LED = {led_busy_q, led_hb_q};

endmodule
